// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
// ---------------
// Bundles the decode-side hazard signals exchanged between the pipeline
// and the hazard controller.
//   slave  : the hazard controller (consumes ID/EX/MEM status, drives
//            forwarding selects, enables, clears, hold, io_err, state)
//   master : the pipeline side (drives status, consumes controls)
// Clock and reset are kept as plain ports on the modules.
interface hazard_ctrl_if;
    // ID-stage instruction and pipeline status
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use1;
    logic       id_use2;
    logic [4:0] id_rd;
    logic       id_RegWrite;
    logic       id_MemRead;
    logic       ex_branch_taken;
    logic       mem_io_req;
    logic       io_ack;
    // Controls back to the pipeline
    logic       fwd_ex_1;
    logic       fwd_mem_1;
    logic       fwd_ex_2;
    logic       fwd_mem_2;
    logic       pc_write;
    logic       if_id_write;
    logic       if_clear;
    logic       id_clear;
    logic       pipe_hold;
    logic       io_err;
    logic [1:0] state;

    modport master (
        output id_rs1, id_rs2, id_use1, id_use2, id_rd, id_RegWrite, id_MemRead,
               ex_branch_taken, mem_io_req, io_ack,
        input  fwd_ex_1, fwd_mem_1, fwd_ex_2, fwd_mem_2, pc_write, if_id_write,
               if_clear, id_clear, pipe_hold, io_err, state
    );

    modport slave (
        input  id_rs1, id_rs2, id_use1, id_use2, id_rd, id_RegWrite, id_MemRead,
               ex_branch_taken, mem_io_req, io_ack,
        output fwd_ex_1, fwd_mem_1, fwd_ex_2, fwd_mem_2, pc_write, if_id_write,
               if_clear, id_clear, pipe_hold, io_err, state
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// -----------
// Hazard and stall controller for the five-stage core. Keeps shadow copies
// of the EX and MEM destination registers, drives operand forwarding
// selects, the load-use bubble, the taken-branch flush sequence and the
// whole-pipeline freeze while a slow I/O access is outstanding.
// Ports:
//   clk  - single clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   hz   - hazard_ctrl_if.slave: ID/EX/MEM status in, controls out
// All controls are combinational from registered state and the ID inputs.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,   // 1..15
    parameter int IO_TIMEOUT   = 255  // 1..255
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        IO_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] IO_LAST    = 8'(IO_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [3:0] flush_cnt_q, flush_cnt_d;
    logic [7:0] io_cnt_q, io_cnt_d;

    // Shadow copies of the instructions now in EX and MEM
    logic [4:0] ex_rd_q, ex_rd_d;
    logic       ex_regwrite_q, ex_regwrite_d;
    logic       ex_memread_q, ex_memread_d;
    logic [4:0] mem_rd_q, mem_rd_d;
    logic       mem_regwrite_q, mem_regwrite_d;

    logic pc_write, if_id_write, if_clear, id_clear, pipe_hold, io_err;

    // Per-operand hazard detection, operand 0 = rs1, operand 1 = rs2
    logic [4:0] src_rs [2];
    logic [1:0] src_use;
    logic [1:0] ex_hit, mem_hit, load_hit, fwd_ex, fwd_mem;
    logic       load_use;

    assign src_rs[0]  = hz.id_rs1;
    assign src_rs[1]  = hz.id_rs2;
    assign src_use[0] = hz.id_use1;
    assign src_use[1] = hz.id_use2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        // A load in EX cannot forward yet; it shows up as a load-use hit instead.
        assign ex_hit[gi]   = src_use[gi] && ex_regwrite_q && !ex_memread_q &&
                              (ex_rd_q != 5'd0) && (ex_rd_q == src_rs[gi]);
        assign mem_hit[gi]  = src_use[gi] && mem_regwrite_q &&
                              (mem_rd_q != 5'd0) && (mem_rd_q == src_rs[gi]);
        assign load_hit[gi] = src_use[gi] && ex_memread_q &&
                              (ex_rd_q != 5'd0) && (ex_rd_q == src_rs[gi]);
        // The younger EX result shadows MEM; a cleared ID slot forwards nothing.
        assign fwd_ex[gi]   = !id_clear && ex_hit[gi];
        assign fwd_mem[gi]  = !id_clear && mem_hit[gi] && !ex_hit[gi];
    end

    assign load_use = |load_hit;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        io_cnt_d    = io_cnt_q;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_clear    = 1'b0;
        id_clear    = 1'b0;
        pipe_hold   = 1'b0;
        io_err      = 1'b0;

        unique case (state_q)
            RUN: begin
                if (hz.mem_io_req) begin
                    // Freeze already in the request cycle
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pipe_hold   = 1'b1;
                    state_d     = IO_WAIT;
                    io_cnt_d    = 8'd0;
                end else if (hz.ex_branch_taken) begin
                    if_clear = 1'b1;
                    id_clear = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = FLUSH;
                        flush_cnt_d = 4'd1;
                    end
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_clear    = 1'b1;
                end
            end
            FLUSH: begin
                if (hz.mem_io_req) begin
                    // Flush is abandoned; the branch still sits in EX and resolves again
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pipe_hold   = 1'b1;
                    state_d     = IO_WAIT;
                    io_cnt_d    = 8'd0;
                end else begin
                    if_clear = 1'b1;
                    id_clear = 1'b1;
                    if (hz.ex_branch_taken) begin
                        flush_cnt_d = 4'd1;
                    end else if (flush_cnt_q == FLUSH_LAST) begin
                        state_d = RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 4'd1;
                    end
                end
            end
            IO_WAIT: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                pipe_hold   = 1'b1;
                if (hz.io_ack) begin
                    state_d = RUN;
                end else if (io_cnt_q == IO_LAST) begin
                    io_err  = 1'b1;
                    state_d = RUN;
                end else begin
                    io_cnt_d = io_cnt_q + 8'd1;
                end
            end
            default: state_d = RUN;
        endcase

        if (rst) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_clear    = 1'b1;
            id_clear    = 1'b1;
            pipe_hold   = 1'b0;
            io_err      = 1'b0;
        end
    end

    // Shadow pipeline advances with the real buffers unless they are frozen.
    always_comb begin
        ex_rd_d        = ex_rd_q;
        ex_regwrite_d  = ex_regwrite_q;
        ex_memread_d   = ex_memread_q;
        mem_rd_d       = mem_rd_q;
        mem_regwrite_d = mem_regwrite_q;
        if (!pipe_hold) begin
            ex_rd_d        = id_clear ? 5'd0 : hz.id_rd;
            ex_regwrite_d  = id_clear ? 1'b0 : hz.id_RegWrite;
            ex_memread_d   = id_clear ? 1'b0 : hz.id_MemRead;
            mem_rd_d       = ex_rd_q;
            mem_regwrite_d = ex_regwrite_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            flush_cnt_q    <= 4'd0;
            io_cnt_q       <= 8'd0;
            ex_rd_q        <= 5'd0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            mem_rd_q       <= 5'd0;
            mem_regwrite_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            io_cnt_q       <= io_cnt_d;
            ex_rd_q        <= ex_rd_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_memread_q   <= ex_memread_d;
            mem_rd_q       <= mem_rd_d;
            mem_regwrite_q <= mem_regwrite_d;
        end
    end

    assign hz.fwd_ex_1    = fwd_ex[0];
    assign hz.fwd_mem_1   = fwd_mem[0];
    assign hz.fwd_ex_2    = fwd_ex[1];
    assign hz.fwd_mem_2   = fwd_mem[1];
    assign hz.pc_write    = pc_write;
    assign hz.if_id_write = if_id_write;
    assign hz.if_clear    = if_clear;
    assign hz.id_clear    = id_clear;
    assign hz.pipe_hold   = pipe_hold;
    assign hz.io_err      = io_err;
    assign hz.state       = state_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// --------------
// Directed scenarios with literal expectations, then randomized traffic.
// A behavioural model (instruction slots for EX/MEM, an "I/O outstanding"
// flag with elapsed-cycle count, and a count of flush cycles still owed)
// predicts every output each cycle; one compare process checks them at
// the falling edge.
module tb_hazard_ctrl;
    localparam int FC = 2;
    localparam int IT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.FLUSH_CYCLES(FC), .IO_TIMEOUT(IT)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [4:0] m_ex_rd, m_mem_rd;
    logic       m_ex_wr, m_ex_ld, m_mem_wr;
    bit         m_io;
    int         m_io_elapsed;
    int         m_flush_left;

    bit   e_pc, e_ifid, e_ifc, e_idc, e_hold, e_err, lu;
    bit   exh1, exh2, memh1, memh2;
    int   e_state;

    initial begin
        m_ex_rd = 0; m_ex_wr = 0; m_ex_ld = 0; m_mem_rd = 0; m_mem_wr = 0;
        m_io = 0; m_io_elapsed = 0; m_flush_left = 0;
    end

    always @(negedge clk) begin
        lu = m_ex_ld && (m_ex_rd != 0) &&
             ((hz.id_use1 && hz.id_rs1 == m_ex_rd) || (hz.id_use2 && hz.id_rs2 == m_ex_rd));
        e_pc = 1; e_ifid = 1; e_ifc = 0; e_idc = 0; e_hold = 0; e_err = 0;
        if (rst) begin
            e_pc = 0; e_ifid = 0; e_ifc = 1; e_idc = 1;
        end else if (m_io) begin
            e_pc = 0; e_ifid = 0; e_hold = 1;
            e_err = !hz.io_ack && (m_io_elapsed + 1 == IT);
        end else if (hz.mem_io_req) begin
            e_pc = 0; e_ifid = 0; e_hold = 1;
        end else if (hz.ex_branch_taken || m_flush_left > 0) begin
            e_ifc = 1; e_idc = 1;
        end else if (lu) begin
            e_pc = 0; e_ifid = 0; e_idc = 1;
        end
        exh1  = hz.id_use1 && m_ex_wr && !m_ex_ld && m_ex_rd != 0 && m_ex_rd == hz.id_rs1;
        exh2  = hz.id_use2 && m_ex_wr && !m_ex_ld && m_ex_rd != 0 && m_ex_rd == hz.id_rs2;
        memh1 = hz.id_use1 && m_mem_wr && m_mem_rd != 0 && m_mem_rd == hz.id_rs1;
        memh2 = hz.id_use2 && m_mem_wr && m_mem_rd != 0 && m_mem_rd == hz.id_rs2;
        e_state = m_io ? 2 : (m_flush_left > 0 ? 1 : 0);

        chk1("pc_write",    hz.pc_write,    e_pc);
        chk1("if_id_write", hz.if_id_write, e_ifid);
        chk1("if_clear",    hz.if_clear,    e_ifc);
        chk1("id_clear",    hz.id_clear,    e_idc);
        chk1("pipe_hold",   hz.pipe_hold,   e_hold);
        chk1("io_err",      hz.io_err,      e_err);
        chk1("fwd_ex_1",    hz.fwd_ex_1,    !e_idc && exh1);
        chk1("fwd_mem_1",   hz.fwd_mem_1,   !e_idc && memh1 && !exh1);
        chk1("fwd_ex_2",    hz.fwd_ex_2,    !e_idc && exh2);
        chk1("fwd_mem_2",   hz.fwd_mem_2,   !e_idc && memh2 && !exh2);
        chkn("state",       8'(hz.state),   8'(e_state));

        // advance to the state after the coming rising edge
        if (rst) begin
            m_ex_rd = 0; m_ex_wr = 0; m_ex_ld = 0; m_mem_rd = 0; m_mem_wr = 0;
            m_io = 0; m_io_elapsed = 0; m_flush_left = 0;
        end else begin
            if (!e_hold) begin
                m_mem_rd = m_ex_rd;
                m_mem_wr = m_ex_wr;
                m_ex_rd  = e_idc ? 5'd0 : hz.id_rd;
                m_ex_wr  = e_idc ? 1'b0 : hz.id_RegWrite;
                m_ex_ld  = e_idc ? 1'b0 : hz.id_MemRead;
            end
            if (m_io) begin
                if (hz.io_ack || m_io_elapsed + 1 >= IT) m_io = 0;
                else m_io_elapsed++;
            end else if (hz.mem_io_req) begin
                m_io = 1; m_io_elapsed = 0; m_flush_left = 0;
            end else if (hz.ex_branch_taken) begin
                m_flush_left = FC - 1;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic wr, input logic ld);
        hz.id_rs1 = rs1; hz.id_use1 = u1; hz.id_rs2 = rs2; hz.id_use2 = u2;
        hz.id_rd = rd; hz.id_RegWrite = wr; hz.id_MemRead = ld;
    endtask

    task automatic set_ctl(input logic br, input logic req, input logic ack);
        hz.ex_branch_taken = br; hz.mem_io_req = req; hz.io_ack = ack;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    task automatic idle(input int n);
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        set_ctl(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    int hold_cnt, err_cnt, err_at, clr_cnt;

    initial begin
        rst = 1'b1;
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        set_ctl(1'b0, 1'b0, 1'b0);

        // Reset outputs
        sample();
        chk1("rst_pc_write", hz.pc_write, 1'b0);
        chk1("rst_if_clear", hz.if_clear, 1'b1);
        chk1("rst_id_clear", hz.id_clear, 1'b1);
        chk1("rst_pipe_hold", hz.pipe_hold, 1'b0);
        chkn("rst_state", 8'(hz.state), 8'd0);
        $display("txn reset: pc_write=%b if_clear=%b", hz.pc_write, hz.if_clear);
        tick();
        rst = 1'b0;
        sample();
        chk1("post_rst_pc_write", hz.pc_write, 1'b1);
        chk1("post_rst_if_clear", hz.if_clear, 1'b0);
        tick();

        // EX forwarding of add x5, then MEM forwarding, then x0 never forwards
        idle(2);
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        sample();
        chk1("fwd_ex_x5", hz.fwd_ex_1, 1'b1);
        chk1("fwd_mem_x5_blocked", hz.fwd_mem_1, 1'b0);
        tick();
        set_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        sample();
        chk1("fwd_mem_x5", hz.fwd_mem_1, 1'b1);
        tick();
        set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        sample();
        chk1("fwd_x0_ex", hz.fwd_ex_1, 1'b0);
        chk1("fwd_x0_mem", hz.fwd_mem_2, 1'b0);
        $display("txn forward: x5 ex/mem, x0 none");
        tick();

        // Load-use on x6 via rs2
        idle(2);
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        set_id(5'd0, 1'b0, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0);
        sample();
        chk1("lu_pc_write", hz.pc_write, 1'b0);
        chk1("lu_id_clear", hz.id_clear, 1'b1);
        chk1("lu_if_clear", hz.if_clear, 1'b0);
        tick();
        sample();
        chk1("lu_after_fwd_mem_2", hz.fwd_mem_2, 1'b1);
        chk1("lu_after_pc_write", hz.pc_write, 1'b1);
        $display("txn load-use: stall then mem forward");
        tick();

        // Taken branch: exactly FC cleared cycles, RUN->FLUSH->RUN
        idle(2);
        clr_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            set_ctl(k == 0, 1'b0, 1'b0);
            sample();
            if (hz.if_clear && hz.id_clear) clr_cnt++;
            if (k == 1) chkn("br_state_flush", 8'(hz.state), 8'd1);
            if (k == 2) chkn("br_state_run", 8'(hz.state), 8'd0);
            tick();
        end
        chkn("br_clear_cycles", 8'(clr_cnt), 8'(FC));
        $display("txn branch: %0d clear cycles", clr_cnt);

        // I/O with ack in the fifth IO_WAIT cycle
        idle(2);
        hold_cnt = 0; err_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            set_ctl(1'b0, k < 5, k == 5);
            sample();
            if (hz.pipe_hold && !hz.pc_write) hold_cnt++;
            if (hz.io_err) err_cnt++;
            if (k == 3) chkn("io_state_wait", 8'(hz.state), 8'd2);
            if (k == 6) chk1("io_resume_pc_write", hz.pc_write, 1'b1);
            tick();
        end
        chkn("io_hold_cycles", 8'(hold_cnt), 8'd6);
        chkn("io_ack_no_err", 8'(err_cnt), 8'd0);
        $display("txn io-ack: hold %0d cycles", hold_cnt);

        // I/O timeout, then ack arriving exactly at the timeout
        for (int pass = 0; pass < 2; pass++) begin
            idle(2);
            err_cnt = 0; err_at = -1;
            for (int k = 0; k < 10; k++) begin
                set_ctl(1'b0, k == 0, pass == 1 && k == IT);
                sample();
                if (hz.io_err) begin err_cnt++; err_at = k; end
                if (k == IT + 1) chkn("io_timeout_state", 8'(hz.state), 8'd0);
                tick();
            end
            if (pass == 0) begin
                chkn("io_timeout_pulses", 8'(err_cnt), 8'd1);
                chkn("io_timeout_cycle", 8'(err_at), 8'(IT));
            end else begin
                chkn("io_ack_at_timeout", 8'(err_cnt), 8'd0);
            end
            $display("txn io-timeout pass %0d: %0d pulses", pass, err_cnt);
        end

        // Branch and load-use together: flush only
        idle(2);
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        set_id(5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        set_ctl(1'b1, 1'b0, 1'b0);
        sample();
        chk1("br_lu_pc_write", hz.pc_write, 1'b1);
        chk1("br_lu_if_clear", hz.if_clear, 1'b1);
        chk1("br_lu_if_id_write", hz.if_id_write, 1'b1);
        tick();
        idle(0);
        sample();
        chkn("br_lu_state", 8'(hz.state), 8'd1);
        $display("txn branch+load-use: flush only");
        tick();

        // Reset while in IO_WAIT
        idle(3);
        set_ctl(1'b0, 1'b1, 1'b0);
        tick();
        set_ctl(1'b0, 1'b0, 1'b0);
        sample();
        chkn("rst_io_state_wait", 8'(hz.state), 8'd2);
        tick();
        rst = 1'b1;
        sample();
        chk1("rst_io_err", hz.io_err, 1'b0);
        tick();
        rst = 1'b0;
        sample();
        chkn("rst_io_state_run", 8'(hz.state), 8'd0);
        chk1("rst_io_hold", hz.pipe_hold, 1'b0);
        $display("txn reset in IO_WAIT: state=%0d", hz.state);
        tick();

        // Randomized traffic, small register range to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            set_id(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 9) < 6),
                   1'($urandom_range(0, 9) < 3));
            set_ctl(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 15) == 0),
                    1'($urandom_range(0, 9) < 2));
            tick();
        end
        rst = 1'b0;
        idle(1);
        $display("txn random: 3000 cycles");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage core. Tracks shadow copies of the EX and MEM destination registers and drives the forwarding selects (fwd_ex_1/2, fwd_mem_1/2) and clear into the ID/EX buffer. Generates the load-use bubble, the branch-taken flush sequence and the whole-pipeline freeze during slow memory-mapped I/O accesses. Sits beside the decode stage; all outputs are valid well before the negedge at which the pipeline buffers sample.

## Interface
Parameters:
- FLUSH_CYCLES, 2: cycles if_clear/id_clear stay asserted after a taken branch (1..15).
- IO_TIMEOUT, 255: max cycles spent in IO_WAIT before forced release (1..255).

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  5  source registers of instruction in ID
- id_use1, id_use2  in  1  instruction in ID actually reads rs1 / rs2
- id_rd  in  5  destination register of instruction in ID
- id_RegWrite, id_MemRead  in  1  control bits of instruction in ID
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- mem_io_req  in  1  MEM stage is accessing slow I/O space
- io_ack  in  1  I/O device completion strobe
- fwd_ex_1, fwd_mem_1, fwd_ex_2, fwd_mem_2  out  1  forwarding selects to ID/EX buffer
- pc_write, if_id_write  out  1  PC / IF-ID buffer update enables
- if_clear, id_clear  out  1  insert bubble into IF/ID, ID/EX
- pipe_hold  out  1  freeze ID/EX and EX/MEM buffers
- io_err  out  1  one-cycle pulse on I/O timeout
- state  out  2  current FSM state (debug)

## Operation
- FSM states: RUN=0, FLUSH=1, IO_WAIT=2. Counters: flush_cnt (4 bits), io_cnt (8 bits).
- Shadow regs: ex_rd/ex_RegWrite/ex_MemRead, mem_rd/mem_RegWrite. When not frozen: ex_* <= id_clear ? 0 : id_*; mem_* <= ex_*. Frozen (pipe_hold=1): both hold.
- Forwarding (combinational, per operand n with rsn/usen):
  - fwd_ex_n = usen && ex_RegWrite && !ex_MemRead && ex_rd!=0 && ex_rd==rsn.
  - fwd_mem_n = usen && mem_RegWrite && mem_rd!=0 && mem_rd==rsn && !fwd_ex_n.
  - All four forced 0 when id_clear=1.
- Load-use hazard: ex_MemRead && ex_rd!=0 && (use1 && rs1==ex_rd || use2 && rs2==ex_rd). In RUN: pc_write=0, if_id_write=0, id_clear=1 for that cycle; no state change (next cycle hazard is gone, MEM forwarding applies).
- Priority each cycle: rst > mem_io_req > ex_branch_taken > load-use > normal.
- RUN: mem_io_req -> IO_WAIT (io_cnt<=0). Else ex_branch_taken -> if_clear=id_clear=1 this cycle; if FLUSH_CYCLES>1 go FLUSH with flush_cnt<=1.
- FLUSH: if_clear=id_clear=1, pc_write=1. flush_cnt increments; when flush_cnt==FLUSH_CYCLES-1 return RUN. New ex_branch_taken restarts at flush_cnt<=1. mem_io_req -> IO_WAIT (flush resumes after? no: flush abandoned; EX branch still held and re-resolves).
- IO_WAIT: pc_write=0, if_id_write=0, pipe_hold=1, clears 0, fwd outputs as computed. io_ack -> RUN. Else io_cnt increments; io_cnt==IO_TIMEOUT-1 without ack -> io_err=1 for one cycle, RUN.
- io_ack outside IO_WAIT ignored.
- Defaults in RUN with no event: pc_write=1, if_id_write=1, clears 0, pipe_hold=0, io_err=0.

## Timing
- Reset: while rst=1 outputs pc_write=0, if_id_write=0, if_clear=1, id_clear=1, pipe_hold=0, fwd_*=0, io_err=0; state<=RUN, counters and shadow regs <=0. First cycle after rst falls: RUN defaults.
- Reset mid-IO_WAIT or mid-FLUSH: RUN next cycle, no io_err pulse.
- Forwarding/stall outputs are combinational from state/shadow regs and ID inputs: zero latency.
- Branch flush spans exactly FLUSH_CYCLES cycles including the cycle ex_branch_taken is seen.
- IO_WAIT entered the cycle after mem_io_req is sampled; freeze is combinational in the request cycle too (pipe_hold=1, pc_write=0 when mem_io_req=1). Exit the cycle after io_ack.
- io_ack on same cycle as timeout: ack wins, no io_err.
- Branch + load-use same cycle: flush only. Branch during IO_WAIT: ignored until return to RUN (EX holds it).

## Test plan
- add x5 in EX, ID reads x5 as rs1 -> fwd_ex_1=1, fwd_mem_1=0; same with rd=x0 -> all fwd 0.
- lw x6 in EX, ID add uses x6 as rs2 -> one cycle pc_write=0, id_clear=1; next cycle fwd_mem_2=1, pc_write=1.
- ex_branch_taken one cycle, FLUSH_CYCLES=2 -> if_clear=id_clear=1 for exactly 2 cycles, state RUN→FLUSH→RUN.
- mem_io_req held, io_ack after 5 cycles -> pipe_hold=1, pc_write=0 for 6 cycles, io_err=0, then RUN.
- mem_io_req held, no ack, IO_TIMEOUT=8 -> io_err single pulse after 8 cycles in IO_WAIT, then RUN.
- ex_branch_taken with load-use hazard same cycle -> flush, no load stall; rst asserted in IO_WAIT -> next cycle state=0, io_err=0.
